// File: rtl/snn_lif_layer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : snn_lif_layer                                         |
// | Brief    : N_IN input LIF neurons, each driven by its own        |
// |            external current, feed one output LIF neuron through  |
// |            programmable weights. Leak, refractory period,        |
// |            saturating arithmetic, run/pause and a weight-write   |
// |            handshake.                                            |
// | Option   : ADAPTIVE_THRESH_EN - output neuron threshold rises    |
// |            on each output spike and relaxes back to THRESH.      |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module snn_lif_layer #(
   parameter int  N_IN        = 3,
   parameter int  CUR_W       = 5,
   parameter int  W           = 8,
   parameter int  WT_W        = 4,
   parameter int  WT_INIT     = 8,
   parameter int  THRESH      = 200,
   parameter int  LEAK_SHIFT  = 3,
   parameter int  REFRAC      = 2,
   parameter int  THRESH_STEP = 16,
   localparam int IDX_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [N_IN*CUR_W-1:0]   ext_current,
   input  logic                    wt_wr_valid,
   input  logic [IDX_W-1:0]        wt_wr_idx,
   input  logic [WT_W-1:0]         wt_wr_data,
   output logic                    wt_wr_ready,
   output logic                    wt_err,
   output logic [N_IN-1:0]         spike_in,
   output logic                    spike_out,
   output logic [W-1:0]            potential_out
);

   localparam int           REF_W    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic [W-1:0] c_vmax   = {W{1'b1}};
   localparam logic [W-1:0] c_thresh = W'(THRESH);

   logic [WT_W-1:0]  r_wt [N_IN];
   logic             r_wt_err;
   logic [N_IN-1:0]  w_spike_in;

   logic [W-1:0]     r_v_out;
   logic [REF_W-1:0] r_ref_out;
   logic             r_spike_out;
   logic [31:0]      w_cur_acc;
   logic [W-1:0]     w_cur_out;
   logic [W+1:0]     w_sum_out;
   logic [W-1:0]     w_sat_out;
   logic             w_fire_out;
   logic [W-1:0]     w_th;

   // Weights may only change while the layer is paused
   assign wt_wr_ready   = ~en;
   assign wt_err        = r_wt_err;
   assign spike_in      = w_spike_in;
   assign spike_out     = r_spike_out;
   assign potential_out = r_v_out;

   // Weight store: accepted writes land in range, out-of-range sets sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_IN; i++) r_wt[i] <= WT_W'(WT_INIT);
         r_wt_err <= 1'b0;
      end else if (wt_wr_valid && !en) begin
         if (int'(wt_wr_idx) < N_IN) r_wt[wt_wr_idx] <= wt_wr_data;
         else                        r_wt_err <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
      logic [W-1:0]     r_v;
      logic [REF_W-1:0] r_ref;
      logic             r_spike;
      logic [W+1:0]     w_sum;
      logic [W-1:0]     w_sat;

      // Leaky integration of the channel current, clamped to the top code
      always_comb begin
         w_sum = {2'b00, r_v} - {2'b00, r_v >> LEAK_SHIFT}
               + {{(W+2-CUR_W){1'b0}}, ext_current[gi*CUR_W +: CUR_W]};
         w_sat = (w_sum > {2'b00, c_vmax}) ? c_vmax : w_sum[W-1:0];
      end

      // Input neuron state: refractory hold, fire-and-reset, or integrate
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_v     <= '0;
            r_ref   <= '0;
            r_spike <= 1'b0;
         end else if (en) begin
            if (r_ref != '0) begin
               r_ref   <= r_ref - REF_W'(1);
               r_v     <= '0;
               r_spike <= 1'b0;
            end else if (w_sat >= c_thresh) begin
               r_spike <= 1'b1;
               r_v     <= '0;
               r_ref   <= REF_W'(REFRAC);
            end else begin
               r_v     <= w_sat;
               r_spike <= 1'b0;
            end
         end else begin
            r_spike <= 1'b0;
         end
      end

      assign w_spike_in[gi] = r_spike;
   end

   // Synaptic current: weights of the registered input spikes, recomputed each cycle
   always_comb begin
      w_cur_acc = '0;
      for (int i = 0; i < N_IN; i++)
         if (w_spike_in[i]) w_cur_acc = w_cur_acc + 32'(r_wt[i]);
      w_cur_out = (w_cur_acc > 32'(c_vmax)) ? c_vmax : w_cur_acc[W-1:0];
   end

   // Output neuron leaky sum and fire decision (never fires while refractory)
   always_comb begin
      w_sum_out  = {2'b00, r_v_out} - {2'b00, r_v_out >> LEAK_SHIFT} + {2'b00, w_cur_out};
      w_sat_out  = (w_sum_out > {2'b00, c_vmax}) ? c_vmax : w_sum_out[W-1:0];
      w_fire_out = (r_ref_out == '0) && (w_sat_out >= w_th);
   end

   // Output neuron state: refractory hold, fire-and-reset, or integrate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v_out     <= '0;
         r_ref_out   <= '0;
         r_spike_out <= 1'b0;
      end else if (en) begin
         if (r_ref_out != '0) begin
            r_ref_out   <= r_ref_out - REF_W'(1);
            r_v_out     <= '0;
            r_spike_out <= 1'b0;
         end else if (w_fire_out) begin
            r_spike_out <= 1'b1;
            r_v_out     <= '0;
            r_ref_out   <= REF_W'(REFRAC);
         end else begin
            r_v_out     <= w_sat_out;
            r_spike_out <= 1'b0;
         end
      end else begin
         r_spike_out <= 1'b0;
      end
   end

`ifdef ADAPTIVE_THRESH_EN
   logic [W-1:0] r_th;
   logic [W:0]   w_th_inc;

   assign w_th_inc = {1'b0, r_th} + (W+1)'(THRESH_STEP);
   assign w_th     = r_th;

   // Adaptive threshold: jump on each output spike, relax by one on other enabled edges
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_th <= c_thresh;
      end else if (en) begin
         if (w_fire_out)
            r_th <= (w_th_inc > {1'b0, c_vmax}) ? c_vmax : w_th_inc[W-1:0];
         else if (r_th > c_thresh)
            r_th <= r_th - W'(1);
      end
   end
`else
   logic [31:0] w_unused_step;

   assign w_th          = c_thresh;
   assign w_unused_step = THRESH_STEP;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_lif_layer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_snn_lif_layer                                      |
// | Brief    : Scoreboard bench for snn_lif_layer. Three builds are  |
// |            driven in lockstep: default, THRESH=255 without leak  |
// |            (saturation), and default threshold without leak      |
// |            (repeated output spikes). Honours ADAPTIVE_THRESH_EN. |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_snn_lif_layer;

   localparam int ND = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic [14:0]       ext_current;
   logic              wt_wr_valid;
   logic [1:0]        wt_wr_idx;
   logic [3:0]        wt_wr_data;
   logic [ND-1:0][2:0] a_si;
   logic [ND-1:0]      a_so;
   logic [ND-1:0]      a_rdy;
   logic [ND-1:0]      a_err;
   logic [ND-1:0][7:0] a_po;

   typedef struct packed {
      logic [ND-1:0][2:0] si;
      logic [ND-1:0]      so;
      logic [ND-1:0][7:0] po;
      logic [ND-1:0]      err;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;

   int n_cmp = 0;
   int n_err = 0;

   // per-build model parameters
   int m_thr [ND] = '{200, 255, 200};
   int m_lk  [ND] = '{3, 8, 8};

   // model state
   int mv   [ND][3];
   int mref [ND][3];
   int mspk [ND][3];
   int mwt  [ND][3];
   int mvo  [ND];
   int mrefo[ND];
   int mspo [ND];
   int merr [ND];
   int mth  [ND];

   always #5 clk = ~clk;

   snn_lif_layer u_dut0 (
      .clk(clk), .reset(reset), .en(en), .ext_current(ext_current),
      .wt_wr_valid(wt_wr_valid), .wt_wr_idx(wt_wr_idx), .wt_wr_data(wt_wr_data),
      .wt_wr_ready(a_rdy[0]), .wt_err(a_err[0]), .spike_in(a_si[0]),
      .spike_out(a_so[0]), .potential_out(a_po[0])
   );

   snn_lif_layer #(.THRESH(255), .LEAK_SHIFT(8)) u_dut1 (
      .clk(clk), .reset(reset), .en(en), .ext_current(ext_current),
      .wt_wr_valid(wt_wr_valid), .wt_wr_idx(wt_wr_idx), .wt_wr_data(wt_wr_data),
      .wt_wr_ready(a_rdy[1]), .wt_err(a_err[1]), .spike_in(a_si[1]),
      .spike_out(a_so[1]), .potential_out(a_po[1])
   );

   snn_lif_layer #(.LEAK_SHIFT(8)) u_dut2 (
      .clk(clk), .reset(reset), .en(en), .ext_current(ext_current),
      .wt_wr_valid(wt_wr_valid), .wt_wr_idx(wt_wr_idx), .wt_wr_data(wt_wr_data),
      .wt_wr_ready(a_rdy[2]), .wt_err(a_err[2]), .spike_in(a_si[2]),
      .spike_out(a_so[2]), .potential_out(a_po[2])
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 3; i++) begin
            mv[d][i] = 0; mref[d][i] = 0; mspk[d][i] = 0; mwt[d][i] = 8;
         end
         mvo[d] = 0; mrefo[d] = 0; mspo[d] = 0; merr[d] = 0; mth[d] = m_thr[d];
      end
   endtask

   // Advance the model by one clock edge using the inputs now applied; push expectation
   task automatic model_step();
      exp_t e;
      int   ns [3];
      int   cur, s, th, fire;
      e = '0;
      for (int d = 0; d < ND; d++) begin
         if (en) begin
            cur = 0;
            for (int i = 0; i < 3; i++) if (mspk[d][i] != 0) cur += mwt[d][i];
            if (cur > 255) cur = 255;
            for (int i = 0; i < 3; i++) begin
               if (mref[d][i] > 0) begin
                  mref[d][i]--; mv[d][i] = 0; ns[i] = 0;
               end else begin
                  s = mv[d][i] - (mv[d][i] >> m_lk[d]) + int'(ext_current[i*5 +: 5]);
                  if (s > 255) s = 255;
                  if (s >= m_thr[d]) begin
                     ns[i] = 1; mv[d][i] = 0; mref[d][i] = 2;
                  end else begin
                     ns[i] = 0; mv[d][i] = s;
                  end
               end
            end
`ifdef ADAPTIVE_THRESH_EN
            th = mth[d];
`else
            th = m_thr[d];
`endif
            fire = 0;
            if (mrefo[d] > 0) begin
               mrefo[d]--; mvo[d] = 0; mspo[d] = 0;
            end else begin
               s = mvo[d] - (mvo[d] >> m_lk[d]) + cur;
               if (s > 255) s = 255;
               if (s >= th) begin
                  fire = 1; mspo[d] = 1; mvo[d] = 0; mrefo[d] = 2;
               end else begin
                  mspo[d] = 0; mvo[d] = s;
               end
            end
`ifdef ADAPTIVE_THRESH_EN
            if (fire != 0) mth[d] = (mth[d] + 16 > 255) ? 255 : mth[d] + 16;
            else if (mth[d] > m_thr[d]) mth[d]--;
`endif
            for (int i = 0; i < 3; i++) mspk[d][i] = ns[i];
         end else begin
            for (int i = 0; i < 3; i++) mspk[d][i] = 0;
            mspo[d] = 0;
            if (wt_wr_valid) begin
               if (wt_wr_idx < 2'd3) mwt[d][wt_wr_idx] = int'(wt_wr_data);
               else                  merr[d] = 1;
            end
         end
         e.si[d]  = {1'(mspk[d][2]), 1'(mspk[d][1]), 1'(mspk[d][0])};
         e.so[d]  = 1'(mspo[d]);
         e.po[d]  = 8'(mvo[d]);
         e.err[d] = 1'(merr[d]);
      end
      sb_q.push_back(e);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard: compare the DUT outputs against the oldest pending expectation
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         m_e = sb_q.pop_front();
         for (int d = 0; d < ND; d++) begin
            check_value($sformatf("d%0d spike_in", d), a_si[d], m_e.si[d]);
            check_value($sformatf("d%0d spike_out", d), a_so[d], m_e.so[d]);
            check_value($sformatf("d%0d potential_out", d), a_po[d], m_e.po[d]);
            check_value($sformatf("d%0d wt_err", d), a_err[d], m_e.err[d]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first0, first1, first2, so_cnt, found;
      reset = 1'b0; en = 1'b0; ext_current = '0;
      wt_wr_valid = 1'b0; wt_wr_idx = '0; wt_wr_data = '0;
      model_reset();
      #12;
      for (int d = 0; d < ND; d++) begin
         check_value($sformatf("reset d%0d spike_in", d), a_si[d], 0);
         check_value($sformatf("reset d%0d spike_out", d), a_so[d], 0);
         check_value($sformatf("reset d%0d potential", d), a_po[d], 0);
         check_value($sformatf("reset d%0d wt_err", d), a_err[d], 0);
         check_value($sformatf("reset d%0d ready", d), a_rdy[d], 1);
      end
      reset = 1'b1;

      // leak integration on channel 0 only
      en = 1'b1; ext_current = 15'd31;
      #1 check_value("ready low while enabled", a_rdy[0], 0);
      first0 = 0; first1 = 0; first2 = 0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (first0 == 0 && a_si[0][0]) first0 = e;
         if (first1 == 0 && a_si[1][0]) first1 = e;
         if (first2 == 0 && a_si[2][0]) first2 = e;
      end
      check_value("first spike_in leak build", first0, 12);
      check_value("first spike_in saturating build", first1, 9);
      check_value("first spike_in no-leak build", first2, 7);

      // pause mid-integration, then resume
      en = 1'b0;
      for (int e = 0; e < 4; e++) tick();
      check_value("ready high while paused", a_rdy[0], 1);
      en = 1'b1;
      for (int e = 0; e < 6; e++) tick();

      // write request while running must be ignored
      ext_current = {5'd31, 5'd31, 5'd31};
      wt_wr_valid = 1'b1; wt_wr_idx = 2'd0; wt_wr_data = 4'd1;
      #1 check_value("ready low with valid while enabled", a_rdy[1], 0);
      for (int e = 0; e < 16; e++) tick();

      // program all weights to 15 while paused, then an out-of-range index
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wt_wr_idx = 2'(k); wt_wr_data = 4'd15;
         #1 check_value($sformatf("ready for write %0d", k), a_rdy[0], 1);
         tick();
      end
      check_value("no error after legal writes", a_err[0], 0);
      wt_wr_idx = 2'd3; wt_wr_data = 4'd5;
      tick();
      wt_wr_valid = 1'b0;
      check_value("sticky error after bad index", a_err[0], 1);

      // all channels driven hard with heavy weights
      en = 1'b1;
      so_cnt = 0;
      for (int e = 0; e < 80; e++) begin
         tick();
         if (a_so[2]) so_cnt++;
      end
      check_value("no-leak build produced output spikes", (so_cnt > 0) ? 1 : 0, 1);

      // reset right after a channel-0 spike, i.e. during its refractory window
      found = 0;
      for (int e = 0; e < 30 && found == 0; e++) begin
         tick();
         if (a_si[0][0]) found = 1;
      end
      check_value("reached refractory window", found, 1);
      reset = 1'b0; en = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         check_value($sformatf("midreset d%0d spike_in", d), a_si[d], 0);
         check_value($sformatf("midreset d%0d spike_out", d), a_so[d], 0);
         check_value($sformatf("midreset d%0d potential", d), a_po[d], 0);
         check_value($sformatf("midreset d%0d wt_err", d), a_err[d], 0);
      end
      model_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;

      // weights back at 8: three simultaneous input spikes give 24 in the output neuron
      en = 1'b1; ext_current = {5'd31, 5'd31, 5'd31};
      for (int e = 0; e < 13; e++) tick();
      check_value("post-reset weighted current", a_po[0], 24);
      for (int e = 0; e < 20; e++) tick();

      @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/snn_lif_layer.md
Name: snn_lif_layer

Overview:
- Parametrised two-layer LIF spiking block: N_IN input LIF neurons, each driven by its own external current, feed one output LIF neuron through programmable synaptic weights.
- Adds over the fixed three-input network:
  - configurable channel count and widths
  - leak
  - refractory period
  - saturating arithmetic
  - run/pause enable
  - weight-programming handshake
- Sits between the stimulus front-end and the spike-observation outputs of the top level.

Parameters:
- N_IN, 3, number of input neurons / synapses (>=1)
- CUR_W, 5, width of each external current
- W, 8, membrane potential width (unsigned)
- WT_W, 4, synaptic weight width (unsigned)
- WT_INIT, 8, reset value of every weight
- THRESH, 200, firing threshold for all neurons
- LEAK_SHIFT, 3, leak = V >> LEAK_SHIFT per update
- REFRAC, 2, refractory updates after a spike (0 = none)
- THRESH_STEP, 16, adaptive threshold increment (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- en  in  1  1 = neurons update each edge; 0 = paused
- ext_current  in  N_IN*CUR_W  packed currents; channel i at bits [i*CUR_W +: CUR_W]
- wt_wr_valid  in  1  weight write request
- wt_wr_idx  in  clog2(N_IN) (min 1)  synapse index
- wt_wr_data  in  WT_W  weight value
- wt_wr_ready  out  1  write can be accepted
- wt_err  out  1  sticky: out-of-range index written
- spike_in  out  N_IN  registered input-neuron spikes
- spike_out  out  1  registered output-neuron spike
- potential_out  out  W  output-neuron membrane potential

Behaviour:
- Reset: reset reset, asynchronous, active-low; clock clk.
  - On reset, all potentials, spike_in, spike_out, refractory counters and wt_err are 0.
  - All weights are WT_INIT.
- Neuron update, per neuron, on each clk edge with en=1:
  - Refractory: if refrac_cnt>0, decrement it, hold V=0, spike=0.
  - Otherwise, compute sum = V - (V>>LEAK_SHIFT) + I in W+2 bits and saturate to 2^W-1.
    - If sum >= THRESH: spike=1, V<=0, refrac_cnt<=REFRAC.
    - Else: V<=sum, spike=0.
- Spikes are single-cycle registered pulses.
- Input neuron i: I = ext_current[i], zero-extended.
- Output neuron: I = sum over i of (spike_in[i] ? weight[i] : 0), using the registered spike_in, saturated to 2^W-1. The current is recomputed each cycle, not accumulated.
- Latency: input threshold crossing at edge k gives spike_in at k; its weighted contribution enters the output neuron at edge k+1; earliest spike_out is edge k+1.
- en=0: potentials, refractory counters and weights hold; spike_in and spike_out forced to 0 at the next edge.
- Weight handshake:
  - wt_wr_ready = ~en. Weights may change only while paused.
  - A write is accepted on an edge with wt_wr_valid & wt_wr_ready; the new weight is used from the first enabled edge after acceptance.
  - wt_wr_idx >= N_IN: write dropped, wt_err<=1 (cleared only by reset).
  - valid while en=1: no write, no error; the master holds valid until ready.
- Reset mid-operation clears everything immediately, including any pending refractory count. Weights return to WT_INIT.
- potential_out = output neuron V, registered.

Optional Feature:
- ADAPTIVE_THRESH_EN defined: the output neuron uses a register th (reset THRESH).
  - On each output spike, th<=min(th+THRESH_STEP, 2^W-1).
  - On every other enabled edge with th>THRESH, th<=th-1.
  - Input neurons keep the fixed THRESH.
- Not defined: the output neuron uses the fixed THRESH and no th register exists.

Test Plan:
- Leak integration: reset, en=1, ext_current[0]=31, others 0.
  - Required: spike_in[0] first high on the 12th enabled edge (V: 31,59,83,104,122,138,152,164,175,185,193,200→fire).
  - Required: V=0 for 2 edges, then 31 on the 15th edge.
  - Required: spike_out stays 0 (8 < 200).
- Weight programming: en=0; write idx0=15, idx1=15, idx2=15, each accepted with ready=1. Then en=1 with all currents=31.
  - Required: output current 45 on edges after input spikes, potential_out rises accordingly; wt_err=0.
- Handshake/error:
  - Valid with en=1: no change and ready=0.
  - Write idx=3 with N_IN=3: wt_err=1, weights unchanged.
- Saturation: THRESH=255 build, current 31, LEAK_SHIFT=8 (no leak).
  - Required: V clamps at 255, spikes, never wraps to a small value.
- Pause/reset: en dropped mid-integration: V holds, spikes 0. Re-enable: continues from the held V. Assert reset mid-refractory: all outputs 0, weights=8.
- ADAPTIVE_THRESH_EN: repeated output spikes.
  - Required: th 200→216→232.
  - Required: decays by 1 per non-spiking edge back to 200.
